fb_write_arbiter: RTL and testbench

- Owns the single write port (wea/addra/dina) of the 320x240 RGB332 framebuffer.
- Shares that port between two pixel-write clients (rasterizer, overlay/debug) using valid/ready handshakes and round-robin arbitration.
- Contains a full-screen clear engine that takes exclusive ownership of the port for one write per cycle.
- Converts (x, y) to a linear address and drops off-screen pixels, counting each drop.

---
 rtl/fb_write_arbiter_if.sv | 45 ++++
 rtl/fb_write_arbiter.sv | 151 +++++++++++++++
 tb/tb_fb_write_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fb_write_arbiter_if.sv
// Framebuffer write-port bundle: clear control, two pixel clients, RGB332 write port, drop counter.
interface fb_write_arbiter_if #(
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned COLOR_W = 8
);
    logic               clr_start;
    logic [COLOR_W-1:0] clr_color;
    logic               clr_busy;
    logic               clr_done;

    logic               req0_valid;
    logic               req0_ready;
    logic [8:0]         req0_x;
    logic [7:0]         req0_y;
    logic [COLOR_W-1:0] req0_color;

    logic               req1_valid;
    logic               req1_ready;
    logic [8:0]         req1_x;
    logic [7:0]         req1_y;
    logic [COLOR_W-1:0] req1_color;

    logic               fb_wea;
    logic [ADDR_W-1:0]  fb_addra;
    logic [COLOR_W-1:0] fb_dina;
    logic [15:0]        drop_count;

    // Client / controller side
    modport master (
        output clr_start, clr_color,
        output req0_valid, req0_x, req0_y, req0_color,
        output req1_valid, req1_x, req1_y, req1_color,
        input  clr_busy, clr_done, req0_ready, req1_ready,
        input  fb_wea, fb_addra, fb_dina, drop_count
    );

    // Arbiter side
    modport slave (
        input  clr_start, clr_color,
        input  req0_valid, req0_x, req0_y, req0_color,
        input  req1_valid, req1_x, req1_y, req1_color,
        output clr_busy, clr_done, req0_ready, req1_ready,
        output fb_wea, fb_addra, fb_dina, drop_count
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Single write-port owner for the RGB332 framebuffer: round-robin between two pixel
// clients, off-screen drop counting, and a full-screen clear engine with exclusive access.
module fb_write_arbiter #(
    parameter int unsigned FB_W    = 320,
    parameter int unsigned FB_H    = 240,
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned COLOR_W = 8
) (
    input  logic              clk,
    input  logic              reset_en,
    fb_write_arbiter_if.slave bus
);
    localparam int unsigned X_W    = 9;
    localparam int unsigned Y_W    = 8;
    localparam int unsigned DROP_W = 16;

    localparam logic [X_W-1:0]    X_LIM    = X_W'(FB_W);
    localparam logic [Y_W-1:0]    Y_LIM    = Y_W'(FB_H);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_W * FB_H - 1);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [ADDR_W-1:0]   clr_cnt;
    logic [COLOR_W-1:0]  clr_col;
    logic                last_grant;
    logic                fb_wea_q;
    logic [ADDR_W-1:0]   fb_addra_q;
    logic [COLOR_W-1:0]  fb_dina_q;
    logic                clr_done_q;
    logic [DROP_W-1:0]   drop_cnt_q;

    logic                clr_last;
    logic                clr_go;
    logic                grant_vld;
    logic                grant_sel;
    logic                rdy0;
    logic                rdy1;

    logic [X_W-1:0]      sel_x;
    logic [Y_W-1:0]      sel_y;
    logic [COLOR_W-1:0]  sel_color;
    logic                sel_in_range;
    logic [ADDR_W-1:0]   sel_addr;

    assign clr_last = (clr_cnt == CLR_LAST);

    // State register; reset aborts any clear in flight
    always_ff @(posedge clk or posedge reset_en) begin
        if (reset_en) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.clr_start) state_nxt = CLEAR;
            CLEAR:   if (clr_last)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant / ready decode; clr_start pre-empts both clients in its cycle
    always_comb begin
        clr_go    = 1'b0;
        grant_vld = 1'b0;
        grant_sel = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clr_start) begin
                    clr_go = 1'b1;
                end else if (bus.req0_valid && bus.req1_valid) begin
                    grant_vld = 1'b1;
                    grant_sel = ~last_grant;
                end else if (bus.req0_valid) begin
                    grant_vld = 1'b1;
                end else if (bus.req1_valid) begin
                    grant_vld = 1'b1;
                    grant_sel = 1'b1;
                end
            end
            default: ;
        endcase
        rdy0 = grant_vld && !grant_sel;
        rdy1 = grant_vld &&  grant_sel;
    end

    always_comb begin
        sel_x        = grant_sel ? bus.req1_x     : bus.req0_x;
        sel_y        = grant_sel ? bus.req1_y     : bus.req0_y;
        sel_color    = grant_sel ? bus.req1_color : bus.req0_color;
        sel_in_range = (sel_x < X_LIM) && (sel_y < Y_LIM);
        sel_addr     = ADDR_W'(sel_y) * ROW_STEP + ADDR_W'(sel_x);
    end

    // Write port, clear engine and drop counter; address/data hold when no write
    always_ff @(posedge clk or posedge reset_en) begin
        if (reset_en) begin
            fb_wea_q   <= 1'b0;
            fb_addra_q <= '0;
            fb_dina_q  <= '0;
            clr_done_q <= 1'b0;
            clr_cnt    <= '0;
            clr_col    <= '0;
            last_grant <= 1'b1;
            drop_cnt_q <= '0;
        end else begin
            fb_wea_q   <= 1'b0;
            clr_done_q <= 1'b0;
            if (state == CLEAR) begin
                fb_wea_q   <= 1'b1;
                fb_addra_q <= clr_cnt;
                fb_dina_q  <= clr_col;
                clr_cnt    <= clr_cnt + ADDR_W'(1);
                clr_done_q <= clr_last;
            end else if (clr_go) begin
                clr_col <= bus.clr_color;
                clr_cnt <= '0;
            end else if (grant_vld) begin
                last_grant <= grant_sel;
                if (sel_in_range) begin
                    fb_wea_q   <= 1'b1;
                    fb_addra_q <= sel_addr;
                    fb_dina_q  <= sel_color;
                end else if (drop_cnt_q != DROP_MAX) begin
                    drop_cnt_q <= drop_cnt_q + DROP_W'(1);
                end
            end
        end
    end

    assign bus.clr_busy   = (state == CLEAR);
    assign bus.clr_done   = clr_done_q;
    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.fb_wea     = fb_wea_q;
    assign bus.fb_addra   = fb_addra_q;
    assign bus.fb_dina    = fb_dina_q;
    assign bus.drop_count = drop_cnt_q;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: vector table for arbitration/addressing/drops,
// plus hand-written sequences for saturation, full clear and reset-abort.
module tb_fb_write_arbiter;
    logic clk;
    logic reset_en;

    fb_write_arbiter_if #(.ADDR_W(17), .COLOR_W(8)) bus ();

    fb_write_arbiter #(
        .FB_W(320), .FB_H(240), .ADDR_W(17), .COLOR_W(8)
    ) dut (
        .clk      (clk),
        .reset_en (reset_en),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [8:0]  x0;
        logic [7:0]  y0;
        logic [7:0]  c0;
        logic        v1;
        logic [8:0]  x1;
        logic [7:0]  y1;
        logic [7:0]  c1;
        logic        r0;
        logic        r1;
        logic        wea;
        logic [16:0] addr;
        logic [7:0]  din;
        logic [15:0] drop;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    int tests;
    int fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        int wr;
        int bad_wr;
        int rdy_leak;
        int done_wr;
        bit done_seen;
        bit mid_pulse;
        logic [16:0] done_addr;
        bit hit;

        tests = 0;
        fails = 0;

        vecs[0]  = '{1'b0, 9'd0,   8'd0,   8'h00, 1'b0, 9'd0,   8'd0,   8'h00, 1'b0, 1'b0, 1'b0, 17'd0,     8'h00, 16'd0};
        vecs[1]  = '{1'b1, 9'd10,  8'd10,  8'hE0, 1'b0, 9'd0,   8'd0,   8'h00, 1'b1, 1'b0, 1'b1, 17'd3210,  8'hE0, 16'd0};
        vecs[2]  = '{1'b0, 9'd0,   8'd0,   8'h00, 1'b1, 9'd319, 8'd239, 8'h1F, 1'b0, 1'b1, 1'b1, 17'd76799, 8'h1F, 16'd0};
        vecs[3]  = '{1'b1, 9'd1,   8'd0,   8'h11, 1'b1, 9'd0,   8'd1,   8'h22, 1'b1, 1'b0, 1'b1, 17'd1,     8'h11, 16'd0};
        vecs[4]  = '{1'b1, 9'd5,   8'd2,   8'h33, 1'b1, 9'd0,   8'd1,   8'h22, 1'b0, 1'b1, 1'b1, 17'd320,   8'h22, 16'd0};
        vecs[5]  = '{1'b1, 9'd5,   8'd2,   8'h33, 1'b1, 9'd100, 8'd100, 8'h44, 1'b1, 1'b0, 1'b1, 17'd645,   8'h33, 16'd0};
        vecs[6]  = '{1'b1, 9'd319, 8'd0,   8'h55, 1'b1, 9'd100, 8'd100, 8'h44, 1'b0, 1'b1, 1'b1, 17'd32100, 8'h44, 16'd0};
        vecs[7]  = '{1'b1, 9'd319, 8'd0,   8'h55, 1'b1, 9'd0,   8'd239, 8'h66, 1'b1, 1'b0, 1'b1, 17'd319,   8'h55, 16'd0};
        vecs[8]  = '{1'b1, 9'd160, 8'd120, 8'h77, 1'b1, 9'd0,   8'd239, 8'h66, 1'b0, 1'b1, 1'b1, 17'd76480, 8'h66, 16'd0};
        vecs[9]  = '{1'b1, 9'd160, 8'd120, 8'h77, 1'b0, 9'd0,   8'd0,   8'h00, 1'b1, 1'b0, 1'b1, 17'd38560, 8'h77, 16'd0};
        vecs[10] = '{1'b0, 9'd0,   8'd0,   8'h00, 1'b1, 9'd320, 8'd5,   8'h99, 1'b0, 1'b1, 1'b0, 17'd38560, 8'h77, 16'd1};
        vecs[11] = '{1'b0, 9'd0,   8'd0,   8'h00, 1'b1, 9'd0,   8'd240, 8'h9A, 1'b0, 1'b1, 1'b0, 17'd38560, 8'h77, 16'd2};
        vecs[12] = '{1'b0, 9'd0,   8'd0,   8'h00, 1'b0, 9'd0,   8'd0,   8'h00, 1'b0, 1'b0, 1'b0, 17'd38560, 8'h77, 16'd2};

        reset_en       = 1'b1;
        bus.clr_start  = 1'b0;
        bus.clr_color  = 8'h00;
        bus.req0_valid = 1'b0;
        bus.req0_x     = '0;
        bus.req0_y     = '0;
        bus.req0_color = '0;
        bus.req1_valid = 1'b0;
        bus.req1_x     = '0;
        bus.req1_y     = '0;
        bus.req1_color = '0;
        repeat (3) @(negedge clk);
        reset_en = 1'b0;
        @(posedge clk); #1;
        check("reset_clr_busy", 32'(bus.clr_busy), 32'd0);
        check("reset_clr_done", 32'(bus.clr_done), 32'd0);
        check("reset_drop",     32'(bus.drop_count), 32'd0);

        // Table-driven arbitration, addressing and drops
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            bus.req0_valid = vecs[i].v0;
            bus.req0_x     = vecs[i].x0;
            bus.req0_y     = vecs[i].y0;
            bus.req0_color = vecs[i].c0;
            bus.req1_valid = vecs[i].v1;
            bus.req1_x     = vecs[i].x1;
            bus.req1_y     = vecs[i].y1;
            bus.req1_color = vecs[i].c1;
            #1;
            check($sformatf("v%0d_req0_ready", i), 32'(bus.req0_ready), 32'(vecs[i].r0));
            check($sformatf("v%0d_req1_ready", i), 32'(bus.req1_ready), 32'(vecs[i].r1));
            @(posedge clk); #1;
            check($sformatf("v%0d_fb_wea", i),     32'(bus.fb_wea),     32'(vecs[i].wea));
            check($sformatf("v%0d_fb_addra", i),   32'(bus.fb_addra),   32'(vecs[i].addr));
            check($sformatf("v%0d_fb_dina", i),    32'(bus.fb_dina),    32'(vecs[i].din));
            check($sformatf("v%0d_drop_count", i), 32'(bus.drop_count), 32'(vecs[i].drop));
        end

        // Drop counter saturation
        @(negedge clk);
        force dut.drop_cnt_q = 16'hFFFD;
        #1;
        release dut.drop_cnt_q;
        bus.req0_valid = 1'b1;
        bus.req0_x     = 9'd400;
        bus.req0_y     = 8'd0;
        bus.req0_color = 8'hC3;
        @(posedge clk); #1;
        check("sat_drop_1", 32'(bus.drop_count), 32'h0000FFFE);
        @(posedge clk); #1;
        check("sat_drop_2", 32'(bus.drop_count), 32'h0000FFFF);
        @(posedge clk); #1;
        check("sat_drop_3", 32'(bus.drop_count), 32'h0000FFFF);
        check("sat_no_write", 32'(bus.fb_wea), 32'd0);
        bus.req0_valid = 1'b0;

        // Full clear with a competing client and an ignored second clr_start
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_x     = 9'd7;
        bus.req0_y     = 8'd3;
        bus.req0_color = 8'hAB;
        bus.clr_start  = 1'b1;
        bus.clr_color  = 8'h01;
        #1;
        check("clr_start_req0_ready", 32'(bus.req0_ready), 32'd0);
        @(posedge clk); #1;
        bus.clr_start = 1'b0;
        check("clr_start_no_write", 32'(bus.fb_wea), 32'd0);
        check("clr_busy_set",       32'(bus.clr_busy), 32'd1);

        wr = 0; bad_wr = 0; rdy_leak = 0; done_wr = 0;
        done_seen = 1'b0; mid_pulse = 1'b0; done_addr = '0;
        for (int cyc = 0; cyc < 80000 && !done_seen; cyc++) begin
            @(posedge clk); #1;
            if (mid_pulse) begin
                bus.clr_start = 1'b0;
                mid_pulse     = 1'b0;
            end
            if (bus.fb_wea) begin
                if (bus.fb_addra !== 17'(wr) || bus.fb_dina !== 8'h01) bad_wr++;
                wr++;
                if (wr == 500) begin
                    bus.clr_start = 1'b1;
                    bus.clr_color = 8'hFF;
                    mid_pulse     = 1'b1;
                end
            end
            if (bus.clr_done) begin
                done_seen = 1'b1;
                done_addr = bus.fb_addra;
                done_wr   = wr;
            end else if (bus.req0_ready) begin
                rdy_leak++;
            end
        end
        check("clr_done_seen",   32'(done_seen), 32'd1);
        check("clr_write_count", 32'(done_wr),   32'd76800);
        check("clr_bad_writes",  32'(bad_wr),    32'd0);
        check("clr_ready_leak",  32'(rdy_leak),  32'd0);
        check("clr_done_addr",   32'(done_addr), 32'd76799);
        check("post_clr_req0_ready", 32'(bus.req0_ready), 32'd1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        check("post_clr_wea",     32'(bus.fb_wea),   32'd1);
        check("post_clr_addr",    32'(bus.fb_addra), 32'd967);
        check("post_clr_din",     32'(bus.fb_dina),  32'hAB);
        check("post_clr_done_lo", 32'(bus.clr_done), 32'd0);
        @(posedge clk); #1;
        check("no_restart_busy", 32'(bus.clr_busy), 32'd0);
        check("no_restart_wea",  32'(bus.fb_wea),   32'd0);

        // Reset asserted mid-clear
        @(negedge clk);
        bus.clr_start = 1'b1;
        bus.clr_color = 8'h3C;
        @(posedge clk); #1;
        bus.clr_start = 1'b0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 2000 && !hit; cyc++) begin
            @(posedge clk); #1;
            if (bus.fb_wea && bus.fb_addra == 17'd1000) hit = 1'b1;
        end
        check("abort_reached_1000", 32'(hit), 32'd1);
        #2;
        reset_en = 1'b1;
        #1;
        check("abort_wea",  32'(bus.fb_wea),     32'd0);
        check("abort_addr", 32'(bus.fb_addra),   32'd0);
        check("abort_din",  32'(bus.fb_dina),    32'd0);
        check("abort_busy", 32'(bus.clr_busy),   32'd0);
        check("abort_done", 32'(bus.clr_done),   32'd0);
        check("abort_drop", 32'(bus.drop_count), 32'd0);
        repeat (2) @(negedge clk);
        reset_en = 1'b0;
        @(posedge clk); #1;
        check("after_abort_done", 32'(bus.clr_done), 32'd0);
        check("after_abort_busy", 32'(bus.clr_busy), 32'd0);

        @(negedge clk);
        bus.clr_start = 1'b1;
        bus.clr_color = 8'h5A;
        @(posedge clk); #1;
        bus.clr_start = 1'b0;
        check("restart_first_no_write", 32'(bus.fb_wea), 32'd0);
        @(posedge clk); #1;
        check("restart_wea0",  32'(bus.fb_wea),   32'd1);
        check("restart_addr0", 32'(bus.fb_addra), 32'd0);
        check("restart_din0",  32'(bus.fb_dina),  32'h5A);
        @(posedge clk); #1;
        check("restart_addr1", 32'(bus.fb_addra), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
